// File: rtl/zregfile_pkg.sv
// Shared types and defaults for the zregfile register file.
// Holds the sweep state encoding and the address-width helper.
package zregfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   function automatic int addr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/zregfile_sweep.sv
// Clear-sweep controller: walks every register index once,
// one per clock, driving a zero-write into the register array.
module zregfile_sweep
   import zregfile_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = addr_w(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLR,
   output logic              BUSY,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         idx   <= '0;
         BUSY  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (CLR) begin
                  state <= SWEEP;
                  idx   <= '0;
                  BUSY  <= 1'b1;
               end
            end
            SWEEP: begin
               if (idx == LAST) begin
                  state <= IDLE;
                  idx   <= '0;
                  BUSY  <= 1'b0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
         endcase
      end
   end

   assign sweep_we   = (state == SWEEP);
   assign sweep_addr = idx;

endmodule

// File: rtl/zregfile.sv
// Two-read, one-write register file with registered write-first reads
// and a hardware clear sweep that takes over the write port while busy.
module zregfile
   import zregfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       WE,
   input  logic [addr_w(DEPTH)-1:0]   WADDR,
   input  logic [WIDTH-1:0]           WDATA,
   input  logic [addr_w(DEPTH)-1:0]   RADDR_A,
   input  logic [addr_w(DEPTH)-1:0]   RADDR_B,
   output logic [WIDTH-1:0]           RDATA_A,
   output logic [WIDTH-1:0]           RDATA_B,
   input  logic                       CLR,
   output logic                       BUSY
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  regs [DEPTH];
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_X;
   endfunction

   zregfile_sweep #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_sweep (
      .CLK       (CLK),
      .RST       (RST),
      .CLR       (CLR),
      .BUSY      (BUSY),
      .sweep_we  (sweep_we),
      .sweep_addr(sweep_addr)
   );

   // Sweep owns the write port; in idle a clear request drops the user write.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = WADDR;
      wr_data = WDATA;
      if (sweep_we) begin
         wr_en   = 1'b1;
         wr_addr = sweep_addr;
         wr_data = '0;
      end else if (WE && !CLR && in_range(WADDR)) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   function automatic logic [WIDTH-1:0] rd_val(input logic [ADDR_W-1:0] a);
      if (!in_range(a)) begin
         return '0;
      end
      if (wr_en && (wr_addr == a)) begin
         return wr_data;
      end
      return regs[a];
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RDATA_A <= '0;
         RDATA_B <= '0;
      end else begin
         RDATA_A <= rd_val(RADDR_A);
         RDATA_B <= rd_val(RADDR_B);
      end
   end

endmodule
